// File: rtl/mux_tree_ctrl_pkg.sv
// Shared types for the operand-bank load / mux-tree evaluation sequencer.
package mux_tree_ctrl_pkg;

   localparam int DATA_W_DEF = 5;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      OP_LOAD_A = 2'd0,
      OP_LOAD_B = 2'd1,
      OP_CLEAR  = 2'd2,
      OP_EVAL   = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/mux_tree_load_ctrl.sv
// Command sequencer: synchronous bank write strobes, loaded/err tracking and a
// settle-timed capture of the mux-tree result.
module mux_tree_load_ctrl
   import mux_tree_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int DATA_W        = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              bank_a_we,
   output logic              bank_b_we,
   output logic [DATA_W-1:0] bank_wdata,
   input  logic              tree_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_data,
   output logic [1:0]        loaded,
   output logic              err
);

   state_e             state_q;
   logic               a_we_q, b_we_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [1:0]         tgt_q;      // {B, A}; both set means CLEAR
   logic [CNT_W-1:0]   cnt_q;
   logic               res_vld_q, res_q;
   logic [1:0]         loaded_q;
   logic               err_q;

   assign cmd_ready  = (state_q == ST_IDLE);
   assign bank_a_we  = a_we_q;
   assign bank_b_we  = b_we_q;
   assign bank_wdata = wdata_q;
   assign res_valid  = res_vld_q;
   assign res_data   = res_q;
   assign loaded     = loaded_q;
   assign err        = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         a_we_q    <= 1'b0;
         b_we_q    <= 1'b0;
         wdata_q   <= '0;
         tgt_q     <= '0;
         cnt_q     <= '0;
         res_vld_q <= 1'b0;
         res_q     <= 1'b0;
         loaded_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         // Strobes are raised on the accepting edge so they cover exactly the WRITE cycle.
         a_we_q <= 1'b0;
         b_we_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op_e'(cmd_op))
                     OP_LOAD_A: begin
                        wdata_q <= cmd_data;
                        tgt_q   <= 2'b01;
                        a_we_q  <= 1'b1;
                        state_q <= ST_WRITE;
                     end
                     OP_LOAD_B: begin
                        wdata_q <= cmd_data;
                        tgt_q   <= 2'b10;
                        b_we_q  <= 1'b1;
                        state_q <= ST_WRITE;
                     end
                     OP_CLEAR: begin
                        wdata_q <= '0;
                        tgt_q   <= 2'b11;
                        a_we_q  <= 1'b1;
                        b_we_q  <= 1'b1;
                        state_q <= ST_WRITE;
                     end
                     default: begin
                        if (loaded_q == 2'b11) begin
                           cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                           state_q <= ST_SETTLE;
                        end else begin
                           err_q <= 1'b1;
                        end
                     end
                  endcase
               end
            end
            ST_WRITE: begin
               if (tgt_q == 2'b11) begin
                  loaded_q <= 2'b00;
                  err_q    <= 1'b0;
               end else begin
                  loaded_q <= loaded_q | tgt_q;
               end
               state_q <= ST_IDLE;
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  res_q     <= tree_out;
                  res_vld_q <= 1'b1;
                  state_q   <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (res_ready) begin
                  res_vld_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_tree_load_ctrl.sv
// Randomized bench for mux_tree_load_ctrl against a command-level model of
// bank validity, error flag and settle-timed result capture.
module tb_mux_tree_load_ctrl;
   import mux_tree_ctrl_pkg::*;

   localparam int S  = 2;
   localparam int DW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [DW-1:0] cmd_data;
   logic          bank_a_we, bank_b_we;
   logic [DW-1:0] bank_wdata;
   logic          tree_out;
   logic          res_valid, res_ready, res_data;
   logic [1:0]    loaded;
   logic          err;

   mux_tree_load_ctrl #(.SETTLE_CYCLES(S), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .bank_a_we(bank_a_we),
      .bank_b_we(bank_b_we), .bank_wdata(bank_wdata), .tree_out(tree_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .loaded(loaded), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Command-level model state
   logic [1:0]    m_loaded;
   logic          m_err;
   logic [DW-1:0] m_wdata;

   // Inputs must hold while a command is stalled
   logic [DW+1:0] prev_cmd;
   logic          prev_v = 1'b0;
   always @(posedge clk) begin
      if (!reset && cmd_valid && !cmd_ready && prev_v)
         chk("stall_hold", {cmd_op, cmd_data}, prev_cmd);
      prev_cmd = {cmd_op, cmd_data};
      prev_v   = cmd_valid && !reset;
   end

   task automatic chk_idle(input string tag);
      chk({tag, "_rdy"}, cmd_ready, 1'b1);
      chk({tag, "_we"}, {bank_b_we, bank_a_we}, 2'b00);
      chk({tag, "_wd"}, bank_wdata, m_wdata);
      chk({tag, "_ld"}, loaded, m_loaded);
      chk({tag, "_err"}, err, m_err);
      chk({tag, "_rv"}, res_valid, 1'b0);
   endtask

   // Called and returns at a negedge.
   task automatic do_write(input logic [1:0] op, input logic [DW-1:0] d);
      logic [1:0]    exp_we;
      logic [DW-1:0] exp_wd;
      chk("wr_rdy_pre", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      @(negedge clk);
      cmd_valid = 1'b0;
      exp_we = (op == OP_CLEAR) ? 2'b11 : (op == OP_LOAD_B) ? 2'b10 : 2'b01;
      exp_wd = (op == OP_CLEAR) ? '0 : d;
      chk("wr_we", {bank_b_we, bank_a_we}, exp_we);
      chk("wr_wd", bank_wdata, exp_wd);
      chk("wr_rdy", cmd_ready, 1'b0);
      chk("wr_ld_old", loaded, m_loaded);
      m_wdata = exp_wd;
      if (op == OP_CLEAR) begin
         m_loaded = 2'b00;
         m_err    = 1'b0;
      end else begin
         m_loaded = m_loaded | exp_we;
      end
      @(negedge clk);
      chk_idle("wr_post");
   endtask

   // force_last >= 0 pins tree_out at the capture edge and drives its inverse before it.
   task automatic do_eval(input int force_last, input int hold);
      logic t, exp_res;
      chk("ev_rdy_pre", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = OP_EVAL; cmd_data = DW'($urandom);
      tree_out = 1'($urandom);
      exp_res = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (m_loaded != 2'b11) begin
         m_err = 1'b1;
         chk_idle("ev_bad");
         return;
      end
      for (int k = 1; k <= S; k++) begin
         chk("ev_settle_rv", res_valid, 1'b0);
         chk("ev_settle_rdy", cmd_ready, 1'b0);
         if (force_last >= 0) t = (k == S) ? 1'(force_last) : ~1'(force_last);
         else                 t = 1'($urandom);
         tree_out = t;
         if (k == S) exp_res = t;
         @(negedge clk);
      end
      tree_out = ~exp_res;
      for (int h = 0; h < hold; h++) begin
         chk("ev_hold_rv", res_valid, 1'b1);
         chk("ev_hold_rd", res_data, exp_res);
         chk("ev_hold_rdy", cmd_ready, 1'b0);
         tree_out = 1'($urandom);
         @(negedge clk);
      end
      chk("ev_rv", res_valid, 1'b1);
      chk("ev_rd", res_data, exp_res);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("ev_done_rv", res_valid, 1'b0);
      chk("ev_done_rdy", cmd_ready, 1'b1);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_loaded = 2'b00; m_err = 1'b0; m_wdata = '0;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
      tree_out = 1'b0; res_ready = 1'b0;
      m_loaded = 2'b00; m_err = 1'b0; m_wdata = '0;
      repeat (2) @(negedge clk);
      chk_idle("rst");
      chk("rst_rd", res_data, 1'b0);
      reset = 1'b0;

      do_write(OP_LOAD_A, 5'h15);
      do_write(OP_LOAD_B, 5'h0A);
      chk("ld_both", loaded, 2'b11);
      do_eval(1, 3);

      apply_reset();
      do_write(OP_LOAD_A, 5'h07);
      do_eval(-1, 0);
      chk("bad_err", err, 1'b1);
      do_write(OP_CLEAR, 5'h1F);
      chk("clr_err", err, 1'b0);

      // Held LOAD_A: accepted every second edge only
      cmd_valid = 1'b1; cmd_op = OP_LOAD_A; cmd_data = 5'h0C;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("b2b_we", bank_a_we, (i % 2 == 0));
         chk("b2b_rdy", cmd_ready, (i % 2 != 0));
      end
      cmd_valid = 1'b0;
      m_loaded = m_loaded | 2'b01; m_wdata = 5'h0C;
      @(negedge clk);
      chk_idle("b2b_post");

      // Reset while settling discards the pending result
      do_write(OP_LOAD_B, 5'h11);
      cmd_valid = 1'b1; cmd_op = OP_EVAL;
      @(negedge clk);
      cmd_valid = 1'b0;
      apply_reset();
      chk_idle("rst_settle");
      for (int i = 0; i < S + 2; i++) begin
         @(negedge clk);
         chk("rst_settle_rv", res_valid, 1'b0);
      end

      do_write(OP_LOAD_A, 5'h03);
      do_write(OP_LOAD_B, 5'h1C);
      do_eval(0, 1);
      do_eval(1, 0);

      for (int n = 0; n < 80; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 2)      do_write(OP_LOAD_A, DW'($urandom));
         else if (r <= 5) do_write(OP_LOAD_B, DW'($urandom));
         else if (r == 6) do_write(OP_CLEAR, DW'($urandom));
         else             do_eval(-1, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
